// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan capture block.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hB;
  localparam logic [3:0] CODE_UNK   = 4'hF;

  typedef enum logic [0:0] {
    SCAN,
    HOLD
  } cap_state_t;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Frame output handshake of seg7_scan_capture (valid/ready plus frame payload).
// SEG7_CAP_DP_EN adds the per-digit decimal-point field out_dp.
interface seg7_scan_capture_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    out_valid;
  logic                    out_ready;
  logic [4*NUM_DIGITS-1:0] out_bcd;
  logic [NUM_DIGITS-1:0]   out_err;
`ifdef SEG7_CAP_DP_EN
  logic [NUM_DIGITS-1:0]   out_dp;

  modport master (output out_valid, output out_bcd, output out_err, output out_dp,
                  input out_ready);
  modport slave  (input out_valid, input out_bcd, input out_err, input out_dp,
                  output out_ready);
`else
  modport master (output out_valid, output out_bcd, output out_err, input out_ready);
  modport slave  (input out_valid, input out_bcd, input out_err, output out_ready);
`endif
endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational active-low 7-segment glyph to BCD code decoder; unknown glyphs flag err.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = CODE_UNK;
    err  = 1'b0;
    case (seg_n)
      GLYPH_0:     code = 4'h0;
      GLYPH_1:     code = 4'h1;
      GLYPH_2:     code = 4'h2;
      GLYPH_3:     code = 4'h3;
      GLYPH_4:     code = 4'h4;
      GLYPH_5:     code = 4'h5;
      GLYPH_6:     code = 4'h6;
      GLYPH_7:     code = 4'h7;
      GLYPH_8:     code = 4'h8;
      GLYPH_9:     code = 4'h9;
      GLYPH_DASH:  code = CODE_DASH;
      GLYPH_BLANK: code = CODE_BLANK;
      default:     err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers per-digit BCD codes from a multiplexed active-low 7-segment bus and presents whole
// frames on a valid/ready interface. Macro SEG7_CAP_DP_EN adds decimal-point capture.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [NUM_DIGITS-1:0] an_n,
`ifdef SEG7_CAP_DP_EN
  input  logic                  dp_n,
`endif
  seg7_scan_capture_if.master   out_if,
  output logic                  overrun
);

`ifdef SEG7_CAP_DP_EN
  localparam int unsigned SW = 8 + NUM_DIGITS;
`else
  localparam int unsigned SW = 7 + NUM_DIGITS;
`endif
  localparam int unsigned   CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [SW-1:0]              pins, meta_q, sync_q, prev_q;
  logic [NUM_DIGITS-1:0]      an_s, act;
  logic [6:0]                 seg_s;
  logic                       one_hot, same, commit;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]      commit_vec;
  logic [3:0]                 dec_code;
  logic                       dec_err;
  logic [NUM_DIGITS-1:0][3:0] code_q;
  logic [NUM_DIGITS-1:0]      derr_q, seen_q, seen_d;
  logic                       frame_done, load, drop;
  cap_state_t                 state_q, state_d;
  logic [4*NUM_DIGITS-1:0]    bcd_q;
  logic [NUM_DIGITS-1:0]      err_q;
  logic                       ovr_q;

`ifdef SEG7_CAP_DP_EN
  logic [NUM_DIGITS-1:0] ddp_q, dp_q;
  assign pins = {dp_n, an_n, seg_n};
`else
  assign pins = {an_n, seg_n};
`endif

  // Synchronizers carry no reset; prev_q holds the sample before sync_q.
  always_ff @(posedge clk) begin
    meta_q <= pins;
    sync_q <= meta_q;
    prev_q <= sync_q;
  end

  assign seg_s   = sync_q[6:0];
  assign an_s    = sync_q[7 +: NUM_DIGITS];
  assign act     = ~an_s;
  assign one_hot = (act != '0) && ((act & (act - NUM_DIGITS'(1))) == '0);
  assign same    = (sync_q == prev_q);

  // Saturating run counter; commit only on the step that reaches CNT_MAX.
  always_comb begin
    cnt_d  = '0;
    commit = 1'b0;
    if (one_hot && same) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d  = cnt_q + CW'(1);
        commit = (cnt_d == CNT_MAX);
      end
    end
  end

  assign commit_vec = commit ? act : '0;

  seg7_glyph_decode u_decode (
    .seg_n (seg_s),
    .code  (dec_code),
    .err   (dec_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      code_q <= {NUM_DIGITS{CODE_BLANK}};
      derr_q <= '0;
      seen_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (commit_vec[i]) begin
          code_q[i] <= dec_code;
          derr_q[i] <= dec_err;
        end
      end
    end
  end

  assign frame_done = &seen_q;
  // A commit on the completion edge belongs to the next frame.
  assign seen_d     = (frame_done ? '0 : seen_q) | commit_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCAN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    if (frame_done) state_d = HOLD;
      HOLD:    if (out_if.out_ready && !frame_done) state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    load = 1'b0;
    drop = 1'b0;
    case (state_q)
      SCAN: load = frame_done;
      HOLD: begin
        load = frame_done && out_if.out_ready;
        drop = frame_done && !out_if.out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= '0;
      err_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (load) begin
        bcd_q <= code_q;
        err_q <= derr_q;
      end
      if (drop) ovr_q <= 1'b1;
    end
  end

`ifdef SEG7_CAP_DP_EN
  // Stored active-high: 1 = decimal point lit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ddp_q <= '0;
      dp_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (commit_vec[i]) ddp_q[i] <= ~sync_q[SW-1];
      end
      if (load) dp_q <= ddp_q;
    end
  end
  assign out_if.out_dp = dp_q;
`endif

  assign out_if.out_valid = (state_q == HOLD);
  assign out_if.out_bcd   = bcd_q;
  assign out_if.out_err   = err_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Randomised and directed bench for seg7_scan_capture against a run-length frame model.
module tb_seg7_scan_capture;
  localparam int ND = 4;
  localparam int SC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    seg_n = 7'h7f;
  logic [ND-1:0] an_n = '1;
  logic          overrun;

  seg7_scan_capture_if #(.NUM_DIGITS(ND)) out_if ();

  seg7_scan_capture #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .seg_n   (seg_n),
    .an_n    (an_n),
    .out_if  (out_if),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph_of(input int v);
    case (v)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Table index doubles as the code: 0..9 digits, 10 = dash (A), 11 = blank (B).
  task automatic decode(input logic [6:0] s, output logic [3:0] c, output logic e);
    c = 4'hF;
    e = 1'b1;
    for (int v = 0; v < 12; v++) begin
      if (glyph_of(v) == s) begin
        c = 4'(v);
        e = 1'b0;
      end
    end
  endtask

  // Model: samples lag the pins by two edges; a digit commits when its run of identical
  // valid samples first reaches SC.
  logic [10:0] h0 = '1, h1 = '1, h2 = '1, smp, prv;
  int          run = 1;
  logic [3:0]  seen = '0;
  logic [15:0] mdig = 16'hBBBB, mbcd = '0;
  logic [3:0]  mderr = '0, merr = '0;
  bit          mvalid = 0, movr = 0, model_ok = 0;

  always @(posedge clk) begin
    logic [3:0] c, act;
    logic       e;
    smp = h1;
    prv = h2;
    h2  = h1;
    h1  = h0;
    h0  = {an_n, seg_n};
    if (rst) begin
      run = 1; seen = '0; mdig = 16'hBBBB; mderr = '0;
      mvalid = 0; movr = 0; mbcd = '0; merr = '0;
      model_ok = 1;
    end else if (model_ok) begin
      if (seen == 4'hF) begin
        if (!mvalid || out_if.out_ready) begin
          mbcd = mdig; merr = mderr; mvalid = 1;
        end else begin
          movr = 1;
        end
        seen = '0;
      end else if (mvalid && out_if.out_ready) begin
        mvalid = 0;
      end
      act = ~smp[10:7];
      if ($countones(act) == 1 && smp == prv) begin
        if (run < SC) begin
          run++;
          if (run == SC) begin
            decode(smp[6:0], c, e);
            for (int i = 0; i < ND; i++) begin
              if (act[i]) begin
                mdig[4*i +: 4] = c;
                mderr[i]       = e;
                seen[i]        = 1'b1;
              end
            end
          end
        end
      end else begin
        run = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("out_valid", 32'(out_if.out_valid), 32'(mvalid));
      check("out_bcd", 32'(out_if.out_bcd), 32'(mbcd));
      check("out_err", 32'(out_if.out_err), 32'(merr));
      check("overrun", 32'(overrun), 32'(movr));
    end
  end

  // rmode: 0 hold ready, 1 random ready, 2 ready exactly when a frame is about to complete
  task automatic drive(input logic [ND-1:0] an, input logic [6:0] g, input int cyc,
                       input int rmode);
    for (int i = 0; i < cyc; i++) begin
      an_n  = an;
      seg_n = g;
      if (rmode == 1) out_if.out_ready = 1'($urandom_range(0, 1));
      else if (rmode == 2) out_if.out_ready = (seen == 4'hF);
      @(negedge clk);
    end
  endtask

  task automatic show(input int d, input logic [6:0] g, input int cyc, input int rmode);
    logic [ND-1:0] an;
    an = ~(ND'(1) << d);
    drive(an, g, cyc, rmode);
  endtask

  task automatic accept_one();
    out_if.out_ready = 1'b1;
    @(negedge clk);
    out_if.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k, dur, d;
    logic [6:0] g;
    out_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(out_if.out_valid), 32'h0);
    check("reset_bcd", 32'(out_if.out_bcd), 32'h0);
    rst = 1'b0;

    show(0, 7'b0100100, 20, 0);
    show(1, 7'b0110000, 20, 0);
    show(2, 7'b0011001, 20, 0);
    show(3, 7'b1000000, 20, 0);
    check("sweep_bcd", 32'(out_if.out_bcd), 32'h0432);
    check("sweep_err", 32'(out_if.out_err), 32'h0);
    check("sweep_valid", 32'(out_if.out_valid), 32'h1);
    accept_one();
    check("accept_drop", 32'(out_if.out_valid), 32'h0);

    for (int t = 0; t < 8; t++) show(1, glyph_of(5 + (t % 2)), 5, 0);
    show(1, glyph_of(7), 12, 0);
    check("toggle_valid", 32'(out_if.out_valid), 32'h0);

    drive(4'b1111, glyph_of(3), 50, 0);
    drive(4'b1100, glyph_of(3), 50, 0);
    check("bad_an_valid", 32'(out_if.out_valid), 32'h0);

    show(1, 7'b0001000, 20, 0);
    show(2, glyph_of(10), 20, 0);
    show(3, glyph_of(11), 20, 0);
    show(0, glyph_of(9), 20, 0);
    check("special_bcd", 32'(out_if.out_bcd), 32'hBAF9);
    check("special_err", 32'(out_if.out_err), 32'h2);
    accept_one();

    for (int i = 0; i < 4; i++) show(i, glyph_of(i + 1), 12, 0);
    for (int i = 0; i < 4; i++) show(i, glyph_of(i + 5), 12, 0);
    check("bp_held_bcd", 32'(out_if.out_bcd), 32'h4321);
    check("bp_overrun", 32'(overrun), 32'h1);
    show(0, glyph_of(9), 12, 0);
    show(1, glyph_of(0), 12, 0);
    show(2, glyph_of(1), 12, 0);
    show(3, glyph_of(2), 14, 2);
    check("bp_reload_bcd", 32'(out_if.out_bcd), 32'h2109);
    check("bp_reload_valid", 32'(out_if.out_valid), 32'h1);
    accept_one();

    show(0, glyph_of(3), 12, 0);
    show(1, glyph_of(4), 12, 0);
    an_n = '1;
    rst  = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    check("midrst_overrun", 32'(overrun), 32'h0);
    check("midrst_bcd", 32'(out_if.out_bcd), 32'h0);
    show(2, glyph_of(7), 12, 0);
    show(3, glyph_of(8), 12, 0);
    check("midrst_partial", 32'(out_if.out_valid), 32'h0);
    show(0, glyph_of(5), 12, 0);
    show(1, glyph_of(6), 12, 0);
    check("midrst_full_bcd", 32'(out_if.out_bcd), 32'h8765);
    check("midrst_full_valid", 32'(out_if.out_valid), 32'h1);

    for (int n = 0; n < 250; n++) begin
      k   = $urandom_range(0, 15);
      dur = $urandom_range(1, 16);
      d   = $urandom_range(0, ND - 1);
      g   = (k < 12) ? glyph_of(k) : 7'($urandom);
      if ($urandom_range(0, 9) == 0) drive(ND'($urandom), g, dur, 1);
      else show(d, g, dur, 1);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
